// File: rtl/tx_encap_pkg.sv
// Shared definitions for the TX encapsulator: FSM states, framing constants
// and the MAC PAUSE frame word builder.
package tx_encap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RDLEN,
        ST_DATA,
        ST_PAUSE,
        ST_GAP
    } state_t;

    localparam logic [63:0] PREAMBLE_WORD   = 64'hd5555555555555FB;
    localparam logic [47:0] PAUSE_DA        = 48'h0100_00c2_8001;
    localparam logic [15:0] PAUSE_ETYPE     = 16'h0888;
    localparam logic [15:0] PAUSE_OPCODE    = 16'h0100;
    localparam logic [15:0] PAUSE_LEN       = 16'd60;
    localparam int          PAUSE_WORDS     = 8;
    localparam logic [7:0]  PAUSE_LAST_KEEP = 8'h0F;

    // Lane 0 is the first byte on the wire, so multi-byte fields appear byte-swapped.
    function automatic logic [63:0] pause_word(
        input logic [2:0]  idx,
        input logic [47:0] sa,
        input logic [15:0] q
    );
        case (idx)
            3'd0:    pause_word = {sa[39:32], sa[47:40], PAUSE_DA};
            3'd1:    pause_word = {PAUSE_OPCODE, PAUSE_ETYPE,
                                   sa[7:0], sa[15:8], sa[23:16], sa[31:24]};
            3'd2:    pause_word = {48'h0, q[7:0], q[15:8]};
            default: pause_word = 64'h0;
        endcase
    endfunction

endpackage

// File: rtl/tx_tick_gen.sv
// Rate divider: one-cycle tick every spd_div+1 clocks; a new divider value
// is picked up only at reload so a running period is never cut short.
module tx_tick_gen #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DIV_W-1:0] spd_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_reg;

    assign tick = (cnt_reg == '0);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= spd_div;
        end else begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

endmodule

// File: rtl/tx_encap_mp.sv
// TX encapsulator: turns length-prefixed FIFO frames into 64-bit XGMII-side
// words, with rate ticking, inter-frame gap, pause reception and PAUSE generation.
module tx_encap_mp
    import tx_encap_pkg::*;
#(
    parameter int DIV_W    = 4,
    parameter int GAP_W    = 6,
    parameter int MAX_LEN  = 9600,
    parameter int PQ_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DIV_W-1:0] spd_div,
    input  logic [GAP_W-1:0] tx_gap,
    input  logic [47:0]      psaddr,
    input  logic [15:0]      tx_pquanta,
    input  logic             txfifo_empty,
    output logic             txfifo_rd_en,
    input  logic [63:0]      txfifo_dout,
    output logic             rts,
    output logic [15:0]      rbytes,
    output logic [63:0]      wdata,
    output logic             wvalid,
    output logic             wlast,
    output logic [7:0]       wkeep,
    input  logic             rx_pause,
    input  logic [15:0]      rx_pvalue,
    output logic             rx_pack,
    input  logic             xreq,
    input  logic             xon,
    output logic             xdone,
    output logic             err_len,
    output logic             underrun
);

    logic             tick;
    state_t           state_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic [15:0]      len_reg;
    logic [15:0]      rd_left_reg;
    logic [15:0]      wr_left_reg;
    logic             pend_reg;
    logic             stall_reg;
    logic [2:0]       pcnt_reg;
    logic [15:0]      ptimer_reg;
    logic [15:0]      qcnt_reg;

    logic             rts_reg, wvalid_reg, wlast_reg, rx_pack_reg;
    logic             xdone_reg, err_len_reg, underrun_reg;
    logic [15:0]      rbytes_reg;
    logic [63:0]      wdata_reg;
    logic [7:0]       wkeep_reg;

    logic             rd_en;
    logic [15:0]      fifo_len;
    logic             len_ok;
    logic [15:0]      len_words;
    logic [15:0]      pause_q;
    logic [7:0]       tail_keep;

    tx_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .rst_    (rst_),
        .spd_div (spd_div),
        .tick    (tick)
    );

    assign fifo_len  = txfifo_dout[15:0];
    assign len_ok    = (fifo_len != 16'd0) && (fifo_len <= 16'(MAX_LEN));
    assign len_words = 16'((17'(fifo_len) + 17'd7) >> 3);
    assign pause_q   = xon ? tx_pquanta : 16'h0;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_keep
            assign tail_keep[gi] = (len_reg[2:0] == 3'd0) || (3'(gi) < len_reg[2:0]);
        end
    endgenerate

    // Read strobe is combinational so the word is ready at the very next tick at full rate.
    always_comb begin
        rd_en = 1'b0;
        if (tick) begin
            case (state_reg)
                ST_IDLE:  rd_en = !xreq && !txfifo_empty && (ptimer_reg == 16'd0);
                ST_RDLEN: rd_en = len_ok && !txfifo_empty;
                ST_DATA:  rd_en = (rd_left_reg != 16'd0) && !txfifo_empty;
                default:  rd_en = 1'b0;
            endcase
        end
    end

    assign txfifo_rd_en = rd_en;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_reg    <= ST_IDLE;
            gap_cnt_reg  <= '0;
            len_reg      <= '0;
            rd_left_reg  <= '0;
            wr_left_reg  <= '0;
            pend_reg     <= 1'b0;
            stall_reg    <= 1'b0;
            pcnt_reg     <= '0;
            ptimer_reg   <= '0;
            qcnt_reg     <= '0;
            rts_reg      <= 1'b0;
            rbytes_reg   <= '0;
            wdata_reg    <= PREAMBLE_WORD;
            wvalid_reg   <= 1'b0;
            wlast_reg    <= 1'b0;
            wkeep_reg    <= '0;
            rx_pack_reg  <= 1'b0;
            xdone_reg    <= 1'b0;
            err_len_reg  <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            rts_reg      <= 1'b0;
            wvalid_reg   <= 1'b0;
            wlast_reg    <= 1'b0;
            wkeep_reg    <= '0;
            wdata_reg    <= PREAMBLE_WORD;
            rx_pack_reg  <= 1'b0;
            xdone_reg    <= 1'b0;
            err_len_reg  <= 1'b0;
            underrun_reg <= 1'b0;

            // A fresh pause request restarts the quantum phase as well as the count.
            if (rx_pause) begin
                ptimer_reg  <= rx_pvalue;
                qcnt_reg    <= '0;
                rx_pack_reg <= 1'b1;
            end else if (tick && (ptimer_reg != 16'd0)) begin
                if (qcnt_reg == 16'(PQ_TICKS - 1)) begin
                    qcnt_reg   <= '0;
                    ptimer_reg <= ptimer_reg - 16'd1;
                end else begin
                    qcnt_reg <= qcnt_reg + 16'd1;
                end
            end

            if (tick) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (xreq) begin
                            state_reg <= ST_PAUSE;
                            pcnt_reg  <= '0;
                        end else if (rd_en) begin
                            state_reg <= ST_RDLEN;
                        end
                    end
                    ST_RDLEN: begin
                        if (!len_ok) begin
                            err_len_reg <= 1'b1;
                            gap_cnt_reg <= tx_gap;
                            state_reg   <= ST_GAP;
                        end else begin
                            rbytes_reg   <= fifo_len;
                            len_reg      <= fifo_len;
                            rts_reg      <= 1'b1;
                            wr_left_reg  <= len_words;
                            rd_left_reg  <= len_words - (rd_en ? 16'd1 : 16'd0);
                            pend_reg     <= rd_en;
                            stall_reg    <= !rd_en;
                            underrun_reg <= !rd_en;
                            state_reg    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (pend_reg) begin
                            wvalid_reg  <= 1'b1;
                            wdata_reg   <= txfifo_dout;
                            wr_left_reg <= wr_left_reg - 16'd1;
                            if (wr_left_reg == 16'd1) begin
                                wlast_reg   <= 1'b1;
                                wkeep_reg   <= tail_keep;
                                gap_cnt_reg <= tx_gap;
                                state_reg   <= ST_GAP;
                            end else begin
                                wkeep_reg <= 8'hFF;
                            end
                        end
                        pend_reg <= rd_en;
                        // Underrun is flagged once per starvation episode, not every stalled tick.
                        if (rd_en) begin
                            rd_left_reg <= rd_left_reg - 16'd1;
                            stall_reg   <= 1'b0;
                        end else if (rd_left_reg != 16'd0) begin
                            stall_reg    <= 1'b1;
                            underrun_reg <= !stall_reg;
                        end
                    end
                    ST_PAUSE: begin
                        wvalid_reg <= 1'b1;
                        wdata_reg  <= pause_word(pcnt_reg, psaddr, pause_q);
                        wkeep_reg  <= 8'hFF;
                        pcnt_reg   <= pcnt_reg + 3'd1;
                        if (pcnt_reg == 3'd0) begin
                            rts_reg    <= 1'b1;
                            rbytes_reg <= PAUSE_LEN;
                        end
                        if (pcnt_reg == 3'(PAUSE_WORDS - 1)) begin
                            wlast_reg   <= 1'b1;
                            wkeep_reg   <= PAUSE_LAST_KEEP;
                            xdone_reg   <= 1'b1;
                            gap_cnt_reg <= tx_gap;
                            state_reg   <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt_reg == '0) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg - 1'b1;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign rts      = rts_reg;
    assign rbytes   = rbytes_reg;
    assign wdata    = wdata_reg;
    assign wvalid   = wvalid_reg;
    assign wlast    = wlast_reg;
    assign wkeep    = wkeep_reg;
    assign rx_pack  = rx_pack_reg;
    assign xdone    = xdone_reg;
    assign err_len  = err_len_reg;
    assign underrun = underrun_reg;

endmodule

// File: tb/tb_tx_encap_mp.sv
// Bench for tx_encap_mp: FIFO model feeding the DUT, byte-level frame model
// as scoreboard, directed corner cases plus randomized frame traffic.
module tb_tx_encap_mp;

    localparam logic [63:0] PRE = 64'hd5555555555555FB;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic [3:0]  spd_div = 4'd0;
    logic [5:0]  tx_gap = 6'd2;
    logic [47:0] psaddr = 48'h001122334455;
    logic [15:0] tx_pquanta = 16'h1234;
    logic        txfifo_empty = 1'b1;
    logic        txfifo_rd_en;
    logic [63:0] txfifo_dout = 64'h0;
    logic        rts;
    logic [15:0] rbytes;
    logic [63:0] wdata;
    logic        wvalid, wlast;
    logic [7:0]  wkeep;
    logic        rx_pause = 1'b0;
    logic [15:0] rx_pvalue = 16'h0;
    logic        rx_pack;
    logic        xreq = 1'b0;
    logic        xon = 1'b1;
    logic        xdone, err_len, underrun;

    always #5 clk = ~clk;

    tx_encap_mp dut (
        .clk(clk), .rst_(rst_), .spd_div(spd_div), .tx_gap(tx_gap),
        .psaddr(psaddr), .tx_pquanta(tx_pquanta),
        .txfifo_empty(txfifo_empty), .txfifo_rd_en(txfifo_rd_en), .txfifo_dout(txfifo_dout),
        .rts(rts), .rbytes(rbytes), .wdata(wdata), .wvalid(wvalid), .wlast(wlast), .wkeep(wkeep),
        .rx_pause(rx_pause), .rx_pvalue(rx_pvalue), .rx_pack(rx_pack),
        .xreq(xreq), .xon(xon), .xdone(xdone), .err_len(err_len), .underrun(underrun)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // FIFO model: data appears one clock after the read strobe.
    logic [63:0] fifo_q[$];
    logic [63:0] held_q[$];

    always @(posedge clk) begin
        if (txfifo_rd_en && fifo_q.size() != 0) begin
            txfifo_dout <= fifo_q.pop_front();
            if (fifo_q.size() == 0) txfifo_empty <= 1'b1;
        end
    end

    task automatic fifo_push(input logic [63:0] w);
        fifo_q.push_back(w);
        txfifo_empty = 1'b0;
    endtask

    // Scoreboard: expected words and per-frame length / pause flag.
    logic [63:0] exp_word_q[$];
    int          exp_len_q[$];
    bit          exp_pause_q[$];

    task automatic push_frame(input int len, input int hold);
        int nw;
        logic [63:0] w;
        nw = (len + 7) / 8;
        fifo_push({$urandom, 16'($urandom), 16'(len)});
        for (int i = 0; i < nw; i++) begin
            w = {$urandom, $urandom};
            exp_word_q.push_back(w);
            if (i < nw - hold) fifo_push(w);
            else held_q.push_back(w);
        end
        exp_len_q.push_back(len);
        exp_pause_q.push_back(1'b0);
    endtask

    task automatic release_held();
        while (held_q.size() != 0) fifo_push(held_q.pop_front());
    endtask

    task automatic expect_pause(input logic [15:0] q);
        logic [7:0]  b[64];
        logic [63:0] w;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        b[0] = 8'h01; b[1] = 8'h80; b[2] = 8'hC2; b[5] = 8'h01;
        for (int i = 0; i < 6; i++) b[6 + i] = psaddr[47 - 8*i -: 8];
        b[12] = 8'h88; b[13] = 8'h08; b[15] = 8'h01;
        b[16] = q[15:8]; b[17] = q[7:0];
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) w[8*j +: 8] = b[8*k + j];
            exp_word_q.push_back(w);
        end
        exp_len_q.push_back(60);
        exp_pause_q.push_back(1'b1);
    endtask

    function automatic logic [7:0] last_keep(input int len);
        int n;
        logic [7:0] k;
        n = len - 8 * ((len + 7) / 8 - 1);
        k = 8'h00;
        for (int i = 0; i < n; i++) k[i] = 1'b1;
        return k;
    endfunction

    // Output monitor, sampled on the falling edge.
    int cyc = 0, last_wv_cyc = 0, word_idx = 0, cur_len = 0;
    bit in_frame = 0, cur_pause = 0, und_in_frame = 0;
    int rts_cnt = 0, err_cnt = 0, und_cnt = 0, xdone_cnt = 0;
    logic [63:0] ew;
    logic        is_last;

    always @(negedge clk) begin
        cyc++;
        if (!rst_) begin
            in_frame = 0; word_idx = 0; und_in_frame = 0;
        end else begin
            if (err_len) err_cnt++;
            if (xdone) xdone_cnt++;
            if (rts) begin
                rts_cnt++;
                check_eq("rts_expected", 64'(exp_len_q.size() != 0), 64'd1);
                if (exp_len_q.size() != 0) begin
                    cur_len   = exp_len_q[0];
                    cur_pause = exp_pause_q[0];
                    check_eq("rbytes", 64'(rbytes), 64'(cur_len));
                end
                in_frame = 1; word_idx = 0; und_in_frame = 0;
            end
            if (underrun) begin und_cnt++; und_in_frame = 1; end
            if (wvalid) begin
                check_eq("word_in_frame", 64'(in_frame), 64'd1);
                check_eq("word_expected", 64'(exp_word_q.size() != 0), 64'd1);
                if (exp_word_q.size() != 0 && in_frame) begin
                    ew = exp_word_q.pop_front();
                    word_idx++;
                    is_last = (word_idx == (cur_len + 7) / 8);
                    check_eq("wdata", wdata, ew);
                    check_eq("wlast", 64'(wlast), 64'(is_last));
                    check_eq("wkeep", 64'(wkeep), 64'(is_last ? last_keep(cur_len) : 8'hFF));
                    if (word_idx > 1 && !und_in_frame)
                        check_eq("tick_spacing", 64'(cyc - last_wv_cyc), 64'(int'(spd_div) + 1));
                    last_wv_cyc = cyc;
                    if (is_last) begin
                        check_eq("xdone", 64'(xdone), 64'(cur_pause));
                        $display("frame len=%0d words=%0d pause=%0d", cur_len, word_idx, cur_pause);
                        void'(exp_len_q.pop_front());
                        void'(exp_pause_q.pop_front());
                        in_frame = 0;
                    end
                end
            end else begin
                check_eq("idle_wdata", wdata, PRE);
            end
        end
    end

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_len_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_in_time", 64'(exp_len_q.size()), 64'd0);
        repeat ((int'(tx_gap) + 4) * (int'(spd_div) + 1)) @(negedge clk);
    endtask

    task automatic send_pause(input logic on, input logic [15:0] q);
        int n;
        xon = on;
        expect_pause(on ? q : 16'h0);
        xreq = 1'b1;
        n = 0;
        while (!rts && n < 50) begin @(negedge clk); n++; end
        xreq = 1'b0;
        wait_done(200);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, r0, e0, u0;
        int divs[4] = '{0, 1, 3, 9};

        repeat (2) @(negedge clk);
        check_eq("rst_wvalid", 64'(wvalid), 64'd0);
        check_eq("rst_wdata", wdata, PRE);
        check_eq("rst_rbytes", 64'(rbytes), 64'd0);
        check_eq("rst_wkeep", 64'(wkeep), 64'd0);
        check_eq("rst_rts", 64'(rts), 64'd0);
        rst_ = 1'b1;
        repeat (2) @(negedge clk);

        // Full rate, 20-byte frame; then quarter rate, 16 bytes.
        push_frame(20, 0);
        wait_done(200);
        check_eq("rbytes_hold", 64'(rbytes), 64'd20);
        spd_div = 4'd3;
        push_frame(16, 0);
        wait_done(200);

        // PAUSE generation, xon=1 then xon=0.
        spd_div = 4'd0;
        send_pause(1'b1, 16'h1234);
        check_eq("xdone_cnt1", 64'(xdone_cnt), 64'd1);
        send_pause(1'b0, 16'h1234);
        check_eq("xdone_cnt2", 64'(xdone_cnt), 64'd2);

        // Received pause of 2 quanta holds off a queued frame.
        rx_pvalue = 16'd2;
        rx_pause  = 1'b1;
        @(negedge clk);
        rx_pause = 1'b0;
        check_eq("rx_pack", 64'(rx_pack), 64'd1);
        push_frame(24, 0);
        n = 0;
        while (!rts && n < 60) begin @(negedge clk); n++; end
        check_eq("pause_holdoff", 64'(n >= 16 && n <= 24), 64'd1);
        wait_done(200);

        // Illegal lengths around the limits, then legal boundary lengths.
        tx_gap = 6'd3;
        r0 = rts_cnt; e0 = err_cnt;
        fifo_push(64'd0);
        fifo_push(64'd9601);
        push_frame(9600, 0);
        push_frame(1, 0);
        wait_done(4000);
        check_eq("err_len_cnt", 64'(err_cnt - e0), 64'd2);
        check_eq("rts_after_err", 64'(rts_cnt - r0), 64'd2);

        // FIFO starves mid-frame, then refills.
        u0 = und_cnt;
        push_frame(40, 3);
        repeat (20) @(negedge clk);
        check_eq("stall_words", 64'(word_idx), 64'd2);
        check_eq("underrun_cnt", 64'(und_cnt - u0), 64'd1);
        release_held();
        wait_done(200);

        // Randomized traffic across rates and gaps.
        for (int it = 0; it < 16; it++) begin
            spd_div = 4'(divs[$urandom % 4]);
            tx_gap  = 6'($urandom_range(0, 5));
            repeat (12) @(negedge clk);
            n = $urandom_range(1, 3);
            for (int f = 0; f < n; f++) push_frame($urandom_range(1, 80), 0);
            wait_done(4000);
        end

        // Reset in the middle of a long frame.
        spd_div = 4'd0;
        repeat (12) @(negedge clk);
        push_frame(800, 0);
        n = 0;
        while (word_idx < 10 && n < 200) begin @(negedge clk); n++; end
        rst_ = 1'b0;
        #1;
        check_eq("midrst_wvalid", 64'(wvalid), 64'd0);
        check_eq("midrst_wlast", 64'(wlast), 64'd0);
        check_eq("midrst_wdata", wdata, PRE);
        check_eq("midrst_rbytes", 64'(rbytes), 64'd0);
        fifo_q.delete(); held_q.delete();
        exp_word_q.delete(); exp_len_q.delete(); exp_pause_q.delete();
        txfifo_empty = 1'b1;
        repeat (3) @(negedge clk);
        rst_ = 1'b1;
        repeat (2) @(negedge clk);
        push_frame(33, 0);
        wait_done(200);
        check_eq("xdone_total", 64'(xdone_cnt), 64'd2);
        check_eq("words_left", 64'(exp_word_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
